femto_sequencer: RTL and testbench
==================================

Name: femto_sequencer

Overview:
- Program sequencer for the femto datapath (opcode + dest/src register fields into register file and ALU).
- Holds a small instruction store, loaded through a valid/ready stream.
- Replays the stored program into the datapath one instruction per cycle: free-run, looped, or single-step.
- Sits between the chip I/O and the decode fields of the femto core, replacing direct pin-driven opcodes.

Parameters:
- OPSIZE, 3, opcode width in bits.
- NUMRF, 2, register address width in bits.
- PDEPTH, 3, log2 of instruction store depth (2**PDEPTH entries).
- Derived IW = OPSIZE+2*NUMRF (7): instruction word {reg_1, reg_0, op}, with op in the LSBs.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- load_en  in  1  level; requests/holds LOAD state.
- load_valid  in  1  instruction word present on load_data.
- load_data  in  IW  instruction word.
- load_ready  out  1  store accepts a word this cycle.
- run  in  1  start free-run from entry 0.
- step  in  1  issue one instruction at pc.
- loop_en  in  1  wrap to entry 0 instead of stopping.
- abort  in  1  stop issuing immediately.
- dp_op  out  OPSIZE  opcode to datapath.
- dp_reg_0  out  NUMRF  dest register address.
- dp_reg_1  out  NUMRF  src register address.
- dp_issue  out  1  dp_* fields are a live instruction this cycle.
- pc  out  PDEPTH  index of next instruction to issue.
- busy  out  1  state is RUN.
- done  out  1  state is DONE.

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; pc=0; prog_len=0; load address=0.
  - All outputs 0. dp_op=0 is the datapath no-op (neither reads nor writes the register file).
  - Store contents are not cleared; they are unreachable because prog_len=0.
- Outputs are registered. dp_* hold 0 whenever dp_issue=0.
- Priority each edge: rst_n > abort > load_en > run > step.
- IDLE:
  - load_en=1: go to LOAD, load address=0.
  - Otherwise run=1 with prog_len>0: go to RUN, pc=0.
  - Otherwise step=1 with prog_len>0: issue mem[pc] for exactly one cycle, then pc = (pc+1 == prog_len) ? 0 : pc+1; remain IDLE.
  - run or step with prog_len=0: ignored.
- LOAD:
  - load_ready = (load address < 2**PDEPTH).
  - A word is accepted only on an edge where load_valid & load_ready: mem[addr] <= load_data, addr++. The address counter is PDEPTH+1 bits.
  - Store full: load_ready=0; further load_valid is dropped; no wrap and no overwrite.
  - load_en=0: go to IDLE with prog_len=addr (0 allowed), pc=0. run/step are ignored while in LOAD.
- RUN:
  - On the edge that samples run, the state becomes RUN and dp_issue=1 with mem[0]; latency 1 cycle.
  - Each following edge issues mem[pc] and advances pc.
  - After issuing entry prog_len-1: if loop_en=1, next cycle issues mem[0] with no bubble. Otherwise go to DONE, dp_issue=0, pc=0.
  - loop_en is sampled at the wrap point only.
  - run re-asserted while in RUN: ignored.
- DONE:
  - done=1.
  - run restarts at entry 0 (same 1-cycle latency).
  - load_en goes to LOAD.
  - step behaves as in IDLE and moves the state to IDLE.
- abort:
  - In RUN/DONE/LOAD: next state IDLE, dp_issue=0 that same next cycle, pc=0.
  - An aborted LOAD keeps prog_len=words accepted.
- busy = (state==RUN); done = (state==DONE). The two are mutually exclusive.

Test Plan:
- Reset, then load 3 words {0x13,0x2A,0x47} with load_valid held high: load_ready=1 for 3 cycles. Drop load_en, then pulse run. Expect dp_issue=1 for exactly 3 consecutive cycles carrying op/reg fields of 0x13, 0x2A, 0x47; then done=1 and dp_issue=0.
- Fill store: stream 10 words into PDEPTH=3. Only the first 8 are accepted; load_ready=0 from the 9th onward. Run and expect 8 issues, then DONE.
- loop_en=1 with a 2-word program: issue sequence w0,w1,w0,w1 with no gap. Assert abort mid-sequence: dp_issue=0 on the next cycle, state IDLE, pc=0.
- Step mode, 3-word program: three step pulses issue w0, w1, w2 each for one cycle; pc goes 1,2,0. A fourth step issues w0.
- run with prog_len=0 and run asserted together with load_en: run ignored, LOAD entered, dp_issue stays 0.
- Drop rst_n while RUN is at pc=2: the next cycle shows all outputs 0 and IDLE; a following run pulse does nothing (prog_len=0).

Source files
------------

// File: rtl/femto_sequencer.sv
// Instruction-store sequencer for the femto datapath: stream-loaded program,
// replayed one word per cycle in free-run, looped or single-step mode.
module femto_sequencer #(
    parameter int OPSIZE = 3,
    parameter int NUMRF  = 2,
    parameter int PDEPTH = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load_en,
    input  logic                        load_valid,
    input  logic [OPSIZE+2*NUMRF-1:0]   load_data,
    output logic                        load_ready,
    input  logic                        run,
    input  logic                        step,
    input  logic                        loop_en,
    input  logic                        abort,
    output logic [OPSIZE-1:0]           dp_op,
    output logic [NUMRF-1:0]            dp_reg_0,
    output logic [NUMRF-1:0]            dp_reg_1,
    output logic                        dp_issue,
    output logic [PDEPTH-1:0]           pc,
    output logic                        busy,
    output logic                        done
);
    localparam int IW    = OPSIZE + 2*NUMRF;
    localparam int DEPTH = 2**PDEPTH;
    localparam logic [PDEPTH:0]   LEN_ONE = 1;
    localparam logic [PDEPTH-1:0] PC_ONE  = 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    state_t              r_state, w_state_nxt;
    logic [PDEPTH-1:0]   r_pc, w_pc_nxt;
    logic [PDEPTH:0]     r_len, w_len_nxt;
    logic [PDEPTH:0]     r_addr, w_addr_nxt;
    logic                r_wrap, w_wrap_nxt;
    logic                r_issue, w_issue_nxt;
    logic [IW-1:0]       r_word, w_word_nxt;
    logic [IW-1:0]       r_mem [DEPTH];

    logic [PDEPTH:0]     w_pc_inc;
    logic [PDEPTH-1:0]   w_pc_adv;
    logic                w_lready;
    logic                w_accept;
    logic                w_has_prog;

    // Address counter is one bit wider than the store so "full" is its MSB.
    assign w_lready   = (r_state == S_LOAD) && !r_addr[PDEPTH];
    assign w_accept   = w_lready && load_valid;
    assign w_pc_inc   = {1'b0, r_pc} + LEN_ONE;
    assign w_pc_adv   = (w_pc_inc == r_len) ? '0 : w_pc_inc[PDEPTH-1:0];
    assign w_has_prog = (r_len != '0);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_len_nxt   = r_len;
        w_addr_nxt  = w_accept ? (r_addr + LEN_ONE) : r_addr;
        w_wrap_nxt  = r_wrap;
        w_issue_nxt = 1'b0;
        w_word_nxt  = '0;
        if (abort) begin
            if (r_state == S_LOAD)
                w_len_nxt = w_addr_nxt;
            w_state_nxt = S_IDLE;
            w_pc_nxt    = '0;
            w_wrap_nxt  = 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (load_en) begin
                        w_state_nxt = S_LOAD;
                        w_addr_nxt  = '0;
                        w_pc_nxt    = '0;
                    end else if (run && w_has_prog) begin
                        w_state_nxt = S_RUN;
                        w_issue_nxt = 1'b1;
                        w_word_nxt  = r_mem[0];
                        w_pc_nxt    = (r_len == LEN_ONE) ? '0 : PC_ONE;
                        w_wrap_nxt  = (r_len == LEN_ONE);
                    end else if (step && w_has_prog) begin
                        w_state_nxt = S_IDLE;
                        w_issue_nxt = 1'b1;
                        w_word_nxt  = r_mem[r_pc];
                        w_pc_nxt    = w_pc_adv;
                    end
                end
                S_LOAD: begin
                    if (!load_en) begin
                        w_state_nxt = S_IDLE;
                        w_len_nxt   = w_addr_nxt;
                        w_pc_nxt    = '0;
                    end
                end
                S_RUN: begin
                    // r_wrap marks that the last entry went out on the previous edge.
                    if (r_wrap && !loop_en) begin
                        w_state_nxt = S_DONE;
                        w_pc_nxt    = '0;
                        w_wrap_nxt  = 1'b0;
                    end else begin
                        w_issue_nxt = 1'b1;
                        w_word_nxt  = r_mem[r_pc];
                        w_pc_nxt    = w_pc_adv;
                        w_wrap_nxt  = (w_pc_inc == r_len);
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_len   <= '0;
            r_addr  <= '0;
            r_wrap  <= 1'b0;
            r_issue <= 1'b0;
            r_word  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_len   <= w_len_nxt;
            r_addr  <= w_addr_nxt;
            r_wrap  <= w_wrap_nxt;
            r_issue <= w_issue_nxt;
            r_word  <= w_word_nxt;
        end
    end

    // Store is never cleared; prog_len=0 after reset hides stale contents.
    always_ff @(posedge clk) begin
        if (rst_n && w_accept)
            r_mem[r_addr[PDEPTH-1:0]] <= load_data;
    end

    assign load_ready = w_lready;
    assign dp_issue   = r_issue;
    assign dp_op      = r_word[OPSIZE-1:0];
    assign dp_reg_0   = r_word[OPSIZE+NUMRF-1:OPSIZE];
    assign dp_reg_1   = r_word[IW-1:OPSIZE+NUMRF];
    assign pc         = r_pc;
    assign busy       = (r_state == S_RUN);
    assign done       = (r_state == S_DONE);
endmodule

// File: tb/tb_femto_sequencer.sv
// Vector-table bench for femto_sequencer: each record drives one clock edge and
// its expected registered outputs go through a scoreboard queue.
module tb_femto_sequencer;
    logic       clk = 1'b0;
    logic       rst_n, load_en, load_valid, run, step, loop_en, abort;
    logic [6:0] load_data;
    logic       load_ready, dp_issue, busy, done;
    logic [2:0] dp_op, pc;
    logic [1:0] dp_reg_0, dp_reg_1;
    logic       tb_finished = 1'b0;

    femto_sequencer #(.OPSIZE(3), .NUMRF(2), .PDEPTH(3)) dut (
        .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_valid(load_valid),
        .load_data(load_data), .load_ready(load_ready), .run(run), .step(step),
        .loop_en(loop_en), .abort(abort), .dp_op(dp_op), .dp_reg_0(dp_reg_0),
        .dp_reg_1(dp_reg_1), .dp_issue(dp_issue), .pc(pc), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rn, le, lv;
        logic [6:0] d;
        logic       run, step, lp, ab;
    } in_t;
    typedef struct packed {
        logic       issue;
        logic [6:0] word;
        logic [2:0] pc;
        logic       busy, done, lr;
    } out_t;
    typedef struct {
        in_t   i;
        out_t  o;
        string name;
    } vec_t;

    vec_t tbl[$];
    out_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic in_t mi(logic rn, logic le, logic lv, logic [6:0] d,
                               logic r, logic s, logic lp, logic ab);
        in_t v;
        v.rn = rn; v.le = le; v.lv = lv; v.d = d;
        v.run = r; v.step = s; v.lp = lp; v.ab = ab;
        return v;
    endfunction

    function automatic out_t mo(logic is, logic [6:0] w, logic [2:0] p,
                                logic b, logic dn, logic lr);
        out_t v;
        v.issue = is; v.word = w; v.pc = p; v.busy = b; v.done = dn; v.lr = lr;
        return v;
    endfunction

    function automatic logic [6:0] fw(int k);
        logic [6:0] w;
        w = 7'((k * 19 + 5) & 32'h7f);
        return w;
    endfunction

    function automatic string fmt(out_t v);
        return $sformatf("issue=%0b word=%h pc=%0d busy=%0b done=%0b ready=%0b",
                         v.issue, v.word, v.pc, v.busy, v.done, v.lr);
    endfunction

    task automatic add(string n, in_t i, out_t o);
        vec_t v;
        v.name = n; v.i = i; v.o = o;
        tbl.push_back(v);
    endtask

    initial begin
        repeat (5000) @(posedge clk);
        if (!tb_finished) begin
            n_fail++;
            $display("FAIL timeout: vector table did not complete within 5000 cycles");
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

    initial begin
        in_t  nop;
        out_t zero;
        out_t got, want;
        nop  = mi(1, 0, 0, 7'h00, 0, 0, 0, 0);
        zero = mo(0, 7'h00, 0, 0, 0, 0);
        rst_n = 1'b0; load_en = 1'b0; load_valid = 1'b0; load_data = '0;
        run = 1'b0; step = 1'b0; loop_en = 1'b0; abort = 1'b0;

        // reset, 3-word load, free run to DONE
        add("reset",      mi(0, 0, 0, 7'h00, 0, 0, 0, 0), zero);
        add("load_enter", mi(1, 1, 0, 7'h00, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 1));
        add("load_w0",    mi(1, 1, 1, 7'h13, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 1));
        add("load_w1",    mi(1, 1, 1, 7'h2A, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 1));
        add("load_w2",    mi(1, 1, 1, 7'h47, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 1));
        add("load_exit",  nop, zero);
        add("run_w0",     mi(1, 0, 0, 7'h00, 1, 0, 0, 0), mo(1, 7'h13, 1, 1, 0, 0));
        add("run_again",  mi(1, 0, 0, 7'h00, 1, 0, 0, 0), mo(1, 7'h2A, 2, 1, 0, 0));
        add("run_w2",     nop, mo(1, 7'h47, 0, 1, 0, 0));
        add("run_done",   nop, mo(0, 0, 0, 0, 1, 0));
        add("done_hold",  nop, mo(0, 0, 0, 0, 1, 0));

        // single step from DONE, then wrap
        add("step_w0",    mi(1, 0, 0, 7'h00, 0, 1, 0, 0), mo(1, 7'h13, 1, 0, 0, 0));
        add("step_gap",   nop, mo(0, 0, 1, 0, 0, 0));
        add("step_w1",    mi(1, 0, 0, 7'h00, 0, 1, 0, 0), mo(1, 7'h2A, 2, 0, 0, 0));
        add("step_w2",    mi(1, 0, 0, 7'h00, 0, 1, 0, 0), mo(1, 7'h47, 0, 0, 0, 0));
        add("step_wrap",  mi(1, 0, 0, 7'h00, 0, 1, 0, 0), mo(1, 7'h13, 1, 0, 0, 0));
        add("step_idle",  nop, mo(0, 0, 1, 0, 0, 0));

        // load_en beats run; overfill the store
        add("load_vs_run", mi(1, 1, 0, 7'h00, 1, 0, 0, 0), mo(0, 0, 0, 0, 0, 1));
        for (int k = 0; k < 10; k++)
            add($sformatf("fill_%0d", k),
                mi(1, 1, 1, fw(k), (k == 2), (k == 8), 0, 0),
                mo(0, 0, 0, 0, 0, (k < 7)));
        add("fill_exit", nop, zero);
        add("fill_run0", mi(1, 0, 0, 7'h00, 1, 0, 0, 0), mo(1, fw(0), 1, 1, 0, 0));
        for (int k = 1; k < 8; k++)
            add($sformatf("fill_run%0d", k), nop, mo(1, fw(k), 3'((k + 1) % 8), 1, 0, 0));
        add("fill_done", nop, mo(0, 0, 0, 0, 1, 0));

        // reset mid-run at pc=2 forgets the program
        add("rerun_w0",   mi(1, 0, 0, 7'h00, 1, 0, 0, 0), mo(1, fw(0), 1, 1, 0, 0));
        add("rerun_w1",   nop, mo(1, fw(1), 2, 1, 0, 0));
        add("rst_in_run", mi(0, 0, 0, 7'h00, 1, 0, 0, 0), zero);
        add("run_empty",  mi(1, 0, 0, 7'h00, 1, 0, 0, 0), zero);
        add("step_empty", mi(1, 0, 0, 7'h00, 0, 1, 0, 0), zero);
        add("load_run_empty", mi(1, 1, 0, 7'h00, 1, 0, 0, 0), mo(0, 0, 0, 0, 0, 1));
        add("exit_empty", nop, zero);
        add("run_len0",   mi(1, 0, 0, 7'h00, 1, 0, 0, 0), zero);

        // looped 2-word program, aborted mid-sequence
        add("lp_load",    mi(1, 1, 0, 7'h00, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 1));
        add("lp_w0",      mi(1, 1, 1, 7'h55, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 1));
        add("lp_w1",      mi(1, 1, 1, 7'h0C, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 1));
        add("lp_exit",    nop, zero);
        add("lp_run",     mi(1, 0, 0, 7'h00, 1, 0, 1, 0), mo(1, 7'h55, 1, 1, 0, 0));
        add("lp_i1",      mi(1, 0, 0, 7'h00, 0, 0, 1, 0), mo(1, 7'h0C, 0, 1, 0, 0));
        add("lp_i2",      mi(1, 0, 0, 7'h00, 0, 0, 1, 0), mo(1, 7'h55, 1, 1, 0, 0));
        add("lp_i3",      mi(1, 0, 0, 7'h00, 0, 0, 1, 0), mo(1, 7'h0C, 0, 1, 0, 0));
        add("lp_i4",      mi(1, 0, 0, 7'h00, 0, 0, 1, 0), mo(1, 7'h55, 1, 1, 0, 0));
        add("lp_abort",   mi(1, 0, 0, 7'h00, 0, 0, 1, 1), zero);
        add("lp_after",   mi(1, 0, 0, 7'h00, 0, 0, 1, 0), zero);

        // aborted LOAD keeps the one accepted word; 1-entry program
        add("ab_load",    mi(1, 1, 0, 7'h00, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 1));
        add("ab_w0",      mi(1, 1, 1, 7'h21, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 1));
        add("ab_abort",   mi(1, 1, 0, 7'h00, 0, 0, 0, 1), zero);
        add("ab_idle",    nop, zero);
        add("ab_run",     mi(1, 0, 0, 7'h00, 1, 0, 0, 0), mo(1, 7'h21, 0, 1, 0, 0));
        add("ab_done",    nop, mo(0, 0, 0, 0, 1, 0));

        for (int n = 0; n < tbl.size(); n++) begin
            rst_n = tbl[n].i.rn; load_en = tbl[n].i.le; load_valid = tbl[n].i.lv;
            load_data = tbl[n].i.d; run = tbl[n].i.run; step = tbl[n].i.step;
            loop_en = tbl[n].i.lp; abort = tbl[n].i.ab;
            exp_q.push_back(tbl[n].o);
            @(posedge clk);
            #1;
            got  = mo(dp_issue, {dp_reg_1, dp_reg_0, dp_op}, pc, busy, done, load_ready);
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want || (busy && done)) begin
                n_fail++;
                $display("FAIL %s: got %s, want %s", tbl[n].name, fmt(got), fmt(want));
            end
            if (!tbl[n].i.rn) begin
                n_checks++;
                if ({dp_issue, dp_op, dp_reg_0, dp_reg_1, pc, busy, done, load_ready} !== '0) begin
                    n_fail++;
                    $display("FAIL %s: reset state not all-zero: %s", tbl[n].name, fmt(got));
                end
            end
        end

        tb_finished = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
